// File: rtl/lfsr_32_bit_checker_pkg.sv
// Shared widths, tap mask and FSM encodings for the 32-bit chunked LFSR
// generator/checker pair.
package lfsr_32_bit_checker_pkg;

    localparam int unsigned LFSR_32_BIT     = 32;
    localparam int unsigned LFSR_8_BIT      = 8;
    localparam logic [7:0]  LFSR_8_BIT_TAPS = 8'hB8;

    typedef logic [1:0] chk_state_t;

    localparam chk_state_t IDLE  = 2'd0;
    localparam chk_state_t CHECK = 2'd1;
    localparam chk_state_t LOST  = 2'd2;

endpackage

// File: rtl/lfsr_32_bit_model.sv
// Expected-state model of the chunked LFSR generator: a 32-bit word register
// fed 8 bits at a time from an 8-bit sub-LFSR.
module lfsr_32_bit_model #(
    parameter int unsigned           LFSR_32_BIT     = lfsr_32_bit_checker_pkg::LFSR_32_BIT,
    parameter int unsigned           LFSR_8_BIT      = lfsr_32_bit_checker_pkg::LFSR_8_BIT,
    parameter logic [LFSR_8_BIT-1:0] LFSR_8_BIT_TAPS = lfsr_32_bit_checker_pkg::LFSR_8_BIT_TAPS
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   Load,
    input  logic                   Step,
    input  logic [LFSR_32_BIT-1:0] Seed,
    output logic [LFSR_32_BIT-1:0] ExpWord
);

    logic [LFSR_32_BIT-1:0] exp_state_q, exp_state_d;
    logic [LFSR_8_BIT-1:0]  lfsr8_q, lfsr8_d, lfsr8_next;

    // ExpWord is the word the generator emits on its next step; Load beats Step.
    always_comb begin
        lfsr8_next  = {lfsr8_q[LFSR_8_BIT-2:0], ^(lfsr8_q & LFSR_8_BIT_TAPS)};
        ExpWord     = {lfsr8_next, exp_state_q[LFSR_32_BIT-1:LFSR_8_BIT]};
        exp_state_d = exp_state_q;
        lfsr8_d     = lfsr8_q;
        if (Load) begin
            exp_state_d = Seed;
            lfsr8_d     = Seed[LFSR_8_BIT-1:0];
        end else if (Step) begin
            exp_state_d = ExpWord;
            lfsr8_d     = lfsr8_next;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            exp_state_q <= '0;
            lfsr8_q     <= '0;
        end else begin
            exp_state_q <= exp_state_d;
            lfsr8_q     <= lfsr8_d;
        end
    end

endmodule

// File: rtl/lfsr_32_bit_checker.sv
// Receive-side PRBS checker: tracks the generator's chunked LFSR sequence and
// reports per-word mismatches, saturating error/word counts and lock status.
module lfsr_32_bit_checker #(
    parameter int unsigned           LFSR_32_BIT     = lfsr_32_bit_checker_pkg::LFSR_32_BIT,
    parameter int unsigned           LFSR_8_BIT      = lfsr_32_bit_checker_pkg::LFSR_8_BIT,
    parameter logic [LFSR_8_BIT-1:0] LFSR_8_BIT_TAPS = lfsr_32_bit_checker_pkg::LFSR_8_BIT_TAPS,
    parameter int unsigned           ERR_CNT_BITS    = 16,
    parameter int unsigned           LOSS_THRESHOLD  = 4
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic                    Load,
    input  logic [LFSR_32_BIT-1:0]  Seed,
    input  logic                    DataValid,
    input  logic [LFSR_32_BIT-1:0]  DataIn,
    output logic                    Locked,
    output logic                    Mismatch,
    output logic [LFSR_32_BIT-1:0]  ErrorBits,
    output logic [ERR_CNT_BITS-1:0] ErrCount,
    output logic [ERR_CNT_BITS-1:0] WordCount
);

    import lfsr_32_bit_checker_pkg::*;

    localparam int unsigned         CONS_BITS = $clog2(LOSS_THRESHOLD + 1);
    localparam logic [CONS_BITS-1:0] CONS_MAX = CONS_BITS'(LOSS_THRESHOLD);

    chk_state_t              state_q, state_d;
    logic [CONS_BITS-1:0]    cons_q, cons_d;
    logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_BITS-1:0] word_cnt_q, word_cnt_d;
    logic [LFSR_32_BIT-1:0]  error_bits_q, error_bits_d;
    logic                    mismatch_q, mismatch_d;
    logic [LFSR_32_BIT-1:0]  exp_word, diff;
    logic                    compare;

    lfsr_32_bit_model #(
        .LFSR_32_BIT    (LFSR_32_BIT),
        .LFSR_8_BIT     (LFSR_8_BIT),
        .LFSR_8_BIT_TAPS(LFSR_8_BIT_TAPS)
    ) u_model (
        .Clock  (Clock),
        .ResetN (ResetN),
        .Load   (Load),
        .Step   (compare),
        .Seed   (Seed),
        .ExpWord(exp_word)
    );

    // A simultaneous Load discards the incoming word: no compare and no model step.
    always_comb begin
        compare      = DataValid && !Load && (state_q != IDLE);
        diff         = DataIn ^ exp_word;
        state_d      = state_q;
        cons_d       = cons_q;
        err_cnt_d    = err_cnt_q;
        word_cnt_d   = word_cnt_q;
        error_bits_d = error_bits_q;
        mismatch_d   = 1'b0;
        if (Load) begin
            state_d      = CHECK;
            cons_d       = '0;
            err_cnt_d    = '0;
            word_cnt_d   = '0;
            error_bits_d = '0;
        end else if (compare) begin
            error_bits_d = diff;
            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
            if (|diff) begin
                mismatch_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                if (cons_q != CONS_MAX) cons_d = cons_q + 1'b1;
            end else begin
                cons_d = '0;
            end
            if (state_q == CHECK && cons_d == CONS_MAX) state_d = LOST;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= IDLE;
            cons_q       <= '0;
            err_cnt_q    <= '0;
            word_cnt_q   <= '0;
            error_bits_q <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cons_q       <= cons_d;
            err_cnt_q    <= err_cnt_d;
            word_cnt_q   <= word_cnt_d;
            error_bits_q <= error_bits_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign Locked    = (state_q == CHECK);
    assign Mismatch  = mismatch_q;
    assign ErrorBits = error_bits_q;
    assign ErrCount  = err_cnt_q;
    assign WordCount = word_cnt_q;

endmodule

// File: tb/tb_lfsr_32_bit_checker.sv
// Scoreboard bench for lfsr_32_bit_checker: a reference generator feeds both a
// default instance and a 4-bit-counter instance; expectations queue per word.
module tb_lfsr_32_bit_checker;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        Load;
    logic [31:0] Seed;
    logic        DataValid;
    logic [31:0] DataIn;

    logic        locked, mismatch, sat_locked, sat_mismatch;
    logic [31:0] error_bits, sat_error_bits;
    logic [15:0] err_count, word_count;
    logic [3:0]  sat_err_count, sat_word_count;

    always #5 Clock = ~Clock;

    lfsr_32_bit_checker dut (
        .Clock(Clock), .ResetN(ResetN), .Load(Load), .Seed(Seed),
        .DataValid(DataValid), .DataIn(DataIn),
        .Locked(locked), .Mismatch(mismatch), .ErrorBits(error_bits),
        .ErrCount(err_count), .WordCount(word_count)
    );

    lfsr_32_bit_checker #(.ERR_CNT_BITS(4)) dut_sat (
        .Clock(Clock), .ResetN(ResetN), .Load(Load), .Seed(Seed),
        .DataValid(DataValid), .DataIn(DataIn),
        .Locked(sat_locked), .Mismatch(sat_mismatch), .ErrorBits(sat_error_bits),
        .ErrCount(sat_err_count), .WordCount(sat_word_count)
    );

    typedef struct {
        logic        mm;
        logic [31:0] eb;
        int unsigned ec;
        int unsigned wc;
        int unsigned ec4;
        int unsigned wc4;
        logic        lk;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference generator state
    logic [31:0] gen_state;
    logic [7:0]  gen_l8;

    // Reference checker state (0 idle, 1 check, 2 lost)
    int unsigned m_state, m_cons, m_err, m_words, m_err4, m_words4;
    logic        m_mm;
    logic [31:0] m_eb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v >= max) ? v : v + 1;
    endfunction

    task automatic gen_step(output logic [31:0] w);
        logic [7:0] l8n;
        l8n       = {gen_l8[6:0], ^(gen_l8 & 8'hB8)};
        w         = {l8n, gen_state[31:8]};
        gen_state = w;
        gen_l8    = l8n;
    endtask

    task automatic model_reset();
        m_state = 0; m_cons = 0; m_err = 0; m_words = 0; m_err4 = 0; m_words4 = 0;
        m_mm = 1'b0; m_eb = '0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.mm = m_mm; e.eb = m_eb; e.ec = m_err; e.wc = m_words;
        e.ec4 = m_err4; e.wc4 = m_words4; e.lk = (m_state == 1);
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_mismatch"},  {31'd0, mismatch},     {31'd0, e.mm});
        check({tag, "_errbits"},   error_bits,            e.eb);
        check({tag, "_errcnt"},    {16'd0, err_count},    e.ec);
        check({tag, "_wordcnt"},   {16'd0, word_count},   e.wc);
        check({tag, "_locked"},    {31'd0, locked},       {31'd0, e.lk});
        check({tag, "_sat_err"},   {28'd0, sat_err_count},  e.ec4);
        check({tag, "_sat_word"},  {28'd0, sat_word_count}, e.wc4);
    endtask

    task automatic send(input logic [31:0] corrupt, input string tag);
        logic [31:0] w;
        @(negedge Clock);
        gen_step(w);
        Load = 1'b0; DataValid = 1'b1; DataIn = w ^ corrupt;
        if (m_state != 0) begin
            m_eb     = corrupt;
            m_mm     = (corrupt != 0);
            m_words  = sat_inc(m_words, 65535);
            m_words4 = sat_inc(m_words4, 15);
            if (m_mm) begin
                m_err  = sat_inc(m_err, 65535);
                m_err4 = sat_inc(m_err4, 15);
                m_cons = sat_inc(m_cons, 4);
            end else begin
                m_cons = 0;
            end
            if (m_state == 1 && m_cons >= 4) m_state = 2;
        end else begin
            m_mm = 1'b0;
        end
        push_expect();
        @(posedge Clock); #1;
        pop_check(tag);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge Clock);
        Load = 1'b0; DataValid = 1'b0;
        m_mm = 1'b0;
        push_expect();
        @(posedge Clock); #1;
        pop_check(tag);
    endtask

    task automatic do_load(input logic [31:0] seed, input logic collide, input string tag);
        @(negedge Clock);
        Load = 1'b1; Seed = seed; DataValid = collide; DataIn = 32'hDEAD_BEEF;
        gen_state = seed; gen_l8 = seed[7:0];
        model_reset();
        m_state = 1;
        push_expect();
        @(posedge Clock); #1;
        pop_check(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},   {31'd0, locked},     32'd0);
        check({tag, "_mismatch"}, {31'd0, mismatch},   32'd0);
        check({tag, "_errbits"},  error_bits,          32'd0);
        check({tag, "_errcnt"},   {16'd0, err_count},  32'd0);
        check({tag, "_wordcnt"},  {16'd0, word_count}, 32'd0);
        check({tag, "_sat_err"},  {28'd0, sat_err_count},  32'd0);
        check({tag, "_sat_word"}, {28'd0, sat_word_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ResetN = 1'b0; Load = 1'b0; Seed = '0; DataValid = 1'b0; DataIn = '0;
        gen_state = '0; gen_l8 = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all_zero("reset");
        @(negedge Clock);
        ResetN = 1'b1;

        // Words before any Load are ignored
        send(32'h0000_0000, "pre_load");

        // Golden run
        do_load(32'h1234_5678, 1'b0, "golden_load");
        for (int i = 1; i <= 100; i++) send(32'h0, "golden");
        check("golden_final_wc", {16'd0, word_count}, 32'd100);
        check("golden_final_ec", {16'd0, err_count},  32'd0);
        idle_cycle("golden_idle");

        // Single-bit error on word 10
        do_load(32'h1234_5678, 1'b0, "single_load");
        for (int i = 1; i <= 100; i++)
            send((i == 10) ? 32'h0000_0001 : 32'h0, "single");
        check("single_final_ec", {16'd0, err_count},  32'd1);
        check("single_final_wc", {16'd0, word_count}, 32'd100);
        check("single_final_lk", {31'd0, locked},     32'd1);

        // Loss of lock: words 20..23 fully inverted
        do_load(32'hCAFE_F00D, 1'b0, "loss_load");
        for (int i = 1; i <= 30; i++)
            send((i >= 20 && i <= 23) ? 32'hFFFF_FFFF : 32'h0, "loss");
        check("loss_final_lk", {31'd0, locked},    32'd0);
        check("loss_final_ec", {16'd0, err_count}, 32'd4);
        do_load(32'hCAFE_F00D, 1'b0, "relock_load");
        send(32'h0, "relock");

        // Load colliding with DataValid mid-stream
        for (int i = 1; i <= 5; i++) send(32'h0, "pre_collide");
        do_load(32'h0BAD_5EED, 1'b1, "collide_load");
        check("collide_wc", {16'd0, word_count}, 32'd0);
        for (int i = 1; i <= 8; i++) send(32'h0, "post_collide");
        send(32'h0000_0400, "post_collide_err");

        // Async reset between edges
        send(32'h0, "pre_reset");
        #2;
        ResetN = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge Clock); #1;
        check_all_zero("async_reset_hold");
        @(negedge Clock);
        ResetN = 1'b1;
        for (int i = 1; i <= 3; i++) send(32'h0, "post_reset_noload");
        check("post_reset_wc", {16'd0, word_count}, 32'd0);

        // Saturation of the 4-bit counters
        do_load(32'h5A5A_A5A5, 1'b0, "sat_load");
        for (int i = 1; i <= 20; i++) send(32'h0000_0100, "sat");
        check("sat_final_ec", {28'd0, sat_err_count},  32'd15);
        check("sat_final_wc", {28'd0, sat_word_count}, 32'd15);
        idle_cycle("sat_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_32_bit_checker.md
# lfsr_32_bit_checker

Receive-side checker for the 32-bit chunked LFSR stream generator. Holds its own copy of the 32-bit expected state plus 8-bit sub-LFSR, seeded from the same 32-bit seed as the generator. Compares each valid received word against the expected word and reports mismatches, error counts and lock status. Sits at the sink of a PRBS link or loopback path and is used for link and datapath self-test.

## Interface
Parameters:
- LFSR_32_BIT, 32: word width.
- LFSR_8_BIT, 8: sub-LFSR width.
- LFSR_8_BIT_TAPS, 8'hB8: feedback tap mask of the 8-bit sub-LFSR.
- ERR_CNT_BITS, 16: width of the error and word counters.
- LOSS_THRESHOLD, 4: consecutive mismatches that drop lock (≥1).

Ports (one clock; reset is asynchronous and active-low):
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous active-low reset.
- Load  in  1  seed strobe; loads Seed into the expected-state model.
- Seed  in  32  same value given to the generator's InitialState.
- DataValid  in  1  DataIn carries one generator word this cycle (mirrors generator Enable).
- DataIn  in  32  received word.
- Locked  out  1  checker is seeded and tracking.
- Mismatch  out  1  one-cycle pulse: last valid word differed.
- ErrorBits  out  32  XOR of last compared word vs expected word.
- ErrCount  out  ERR_CNT_BITS  total mismatched words, saturating.
- WordCount  out  ERR_CNT_BITS  total compared words, saturating.

## Operation
- Model registers: ExpState[31:0] and Lfsr8[7:0].
- Step function:
  - Lfsr8Next = {Lfsr8[6:0], ^(Lfsr8 & LFSR_8_BIT_TAPS)}.
  - ExpWord = {Lfsr8Next, ExpState[31:8]}.
  - On a step, ExpState <= ExpWord and Lfsr8 <= Lfsr8Next.
- Load (any state): ExpState <= Seed, Lfsr8 <= Seed[7:0]. Clears ErrCount, WordCount, ErrorBits and the consecutive-mismatch counter. Next state is CHECK.
- FSM states:
  - IDLE: entered on reset. DataValid is ignored. Locked=0.
  - CHECK: Locked=1. Each DataValid compares DataIn with ExpWord:
    - Match: clears the consecutive-mismatch counter.
    - Mismatch: pulses Mismatch, increments ErrCount and the consecutive-mismatch counter.
    - When the consecutive count reaches LOSS_THRESHOLD, go to LOST.
  - LOST: Locked=0. Comparison and counting continue. Only Load returns to CHECK.
- Every valid word steps the model, match or not, because the generator advanced too.
- Every compared word updates ErrorBits and increments WordCount.
- Counters saturate at all-ones and do not wrap.
- Simultaneous Load and DataValid: Load wins, the word is discarded, no compare, no step.
- Reset mid-operation: all state returns to reset values immediately, independent of Clock.

## Timing
- Reset values: Locked=0, Mismatch=0, ErrorBits=0, ErrCount=0, WordCount=0, state IDLE, ExpState=0, Lfsr8=0.
- All outputs are registered. A word sampled at edge N shows its Mismatch, ErrorBits and counter updates after edge N; they are visible in cycle N+1.
- Locked rises the cycle after the Load edge.
- Locked falls the cycle after the edge that sampled the LOSS_THRESHOLD-th consecutive mismatch.
- Mismatch is high for exactly one cycle per mismatched word. Back-to-back bad words give Mismatch high continuously.
- No backpressure: one word per DataValid cycle, full throughput.

## Structure
- Shared parameters file holds LFSR_32_BIT, LFSR_8_BIT, LFSR_8_BIT_TAPS and the FSM state encodings (IDLE=2'd0, CHECK=2'd1, LOST=2'd2).
- One sub-module, lfsr_32_bit_model:
  - Contents: ExpState and Lfsr8 registers with Load/Step inputs and an ExpWord output.
  - Purpose: also reusable by a future generator-side self-check.
- The top level holds the FSM, the comparator, the counters and the output registers.

## Test plan
- Golden run: generator and checker both seeded 32'h1234_5678, 100 valid cycles.
  - Expected: Locked=1 from the cycle after Load, Mismatch never asserted.
  - Final values: ErrCount=0, WordCount=100.
- Single-bit error: flip DataIn[0] on word 10.
  - Cycle after: Mismatch=1 for one cycle, ErrorBits=32'h0000_0001.
  - Final values: ErrCount=1, Locked stays 1, WordCount=100 after 100 words.
- Loss of lock: corrupt words 20–23 with 32'hFFFF_FFFF XOR.
  - Locked falls the cycle after word 23; ErrCount=4.
  - Clean words afterwards do not restore lock; Load then Locked=1 with counters at 0.
- Load collides with DataValid (same edge, mid-stream): that word is not counted (WordCount=0 next cycle). The model equals Seed, and the next generator word after its re-seed matches.
- Async reset: drop ResetN mid-stream between clock edges.
  - Immediately: all outputs are 0 and the state is IDLE.
  - After release: DataValid without Load leaves WordCount=0.
- Saturation: ERR_CNT_BITS=4, 20 corrupted words. ErrCount=15 and WordCount=15, both held with no wrap.
